mem_access_unit: RTL and testbench
==================================

# mem_access_unit

Load/store front-end sitting directly upstream of the byte-addressed little-endian data memory. It accepts one load or store request at a time from the execute stage and always presents word-aligned addresses to memory. Byte and halfword stores become a read-modify-write pair, because the memory only writes whole 32-bit words. Load results are extracted from the addressed lane, zero- or sign-extended, and returned as a registered result with a one-cycle valid pulse.

## Interface
- No parameters; data and address widths are fixed at 32.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `req`  in  1  access request; sampled only when `ready`=1.
- `we`  in  1  1 = store, 0 = load.
- `size`  in  2  00 byte, 01 half, 10 word, 11 reserved.
- `sign_ext`  in  1  loads only: 1 sign-extends, 0 zero-extends.
- `addr`  in  32  byte address.
- `wdata`  in  32  store data; the value is taken from the low bits for byte and half.
- `ready`  out  1  high exactly when the FSM is in IDLE.
- `rvalid`  out  1  one-cycle pulse when `rdata` holds a new load result.
- `rdata`  out  32  registered, extended load result; held until the next load completes.
- `fault`  out  1  one-cycle pulse on a rejected access; tied 0 when the configuration macro is absent.
- `mem_we`  out  1  to the memory write enable; registered.
- `mem_addr`  out  32  to the memory address; always `{addr[31:2],2'b00}`; registered.
- `mem_wdata`  out  32  to the memory write data; registered.
- `mem_rdata`  in  32  from the memory combinational read port.

## Operation
- **FSM states:** IDLE, LOAD, RD, WR, FAULT.
- **Accept:** a request is accepted on an edge where `req & ready`. `we`, `size`, `sign_ext`, `addr` and `wdata` are captured on that edge. Inputs are ignored outside accept; there is no queueing.
- **Next state from IDLE on accept:**
  - load → LOAD
  - word store → WR
  - byte or half store → RD
  - fault condition → FAULT
- **Lane selection:** `lane = addr[1:0]`.
  - Byte lane k is `[8k+7:8k]`.
  - Half uses `addr[1]`: 0 selects `[15:0]`, 1 selects `[31:16]`.
- **LOAD:** `mem_addr` = aligned address. On the leaving edge, `rdata` ← extracted lane extended to 32 bits, `rvalid`←1, and the FSM returns to IDLE.
- **RD:** `mem_we`=0. On the leaving edge, `mem_wdata` ← `mem_rdata` with the selected lane replaced by `wdata[7:0]` or `wdata[15:0]`, `mem_we`←1, and the FSM moves to WR.
- **WR:** `mem_we`=1 for exactly one cycle, so memory commits on the edge leaving WR. For a word store, `mem_wdata`=`wdata`. The FSM then returns to IDLE.
- **FAULT:** `fault`=1 for one cycle. `mem_we` stays 0 and `rvalid` stays 0. The FSM then returns to IDLE.
- **Reset (`rst_n` low):**
  - FSM enters IDLE immediately, so `ready`=1.
  - `rvalid`, `rdata`, `fault`, `mem_we`, `mem_addr` and `mem_wdata` all go to 0.
  - A reset arriving in RD or WR drops `mem_we` asynchronously, so no partial store commits.

## Timing
Accept edge ends cycle T.
- **Load:** LOAD in T+1; `rvalid`=1 and `rdata` valid in T+2; `ready`=1 in T+2.
- **Word store:** `mem_we`=1 in T+1; `ready`=1 in T+2.
- **Byte/half store:** RD in T+1; `mem_we`=1 in T+2; `ready`=1 in T+3.
- **Fault:** `fault`=1 in T+1; `ready`=1 in T+2.
- **Back-to-back:** a new request may be accepted on the first edge with `ready`=1. The `rvalid` of the previous load may coincide with that accept.
- `ready` is combinational from state only; it never depends on `req`.

## Configuration
- **`MEM_ACCESS_ALIGN_CHECK_EN` defined — fault conditions:**
  - half with `addr[0]`=1
  - word with `addr[1:0]`≠0
  - `size`=11

  Any of these goes to FAULT with no memory access.
- **`MEM_ACCESS_ALIGN_CHECK_EN` absent:**
  - `fault` is tied 0 and the FAULT state is not built.
  - Half ignores `addr[0]`; word ignores `addr[1:0]`.
  - `size`=11 is treated as word.

## Test plan
- **Reset:** hold `rst_n`=0 mid-run → `ready`=1, `mem_we`=0, `rvalid`=0, `rdata`=0x00000000 with no clock edge needed.
- **Word store:** store at `addr` 0x10, `wdata` 0xDEADBEEF → in T+1, `mem_we`=1, `mem_addr`=0x10, `mem_wdata`=0xDEADBEEF; `ready`=1 in T+2.
- **Byte store:** with memory word 0x10 = 0xDEADBEEF, byte store at 0x12 with `wdata` 0x000000A5 → T+1: `mem_we`=0, `mem_addr`=0x10; T+2: `mem_we`=1, `mem_wdata`=0xDEA5BEEF; `ready` in T+3.
- **Loads** from word 0xDEA5BEEF; each gives `rvalid` as a single-cycle pulse in T+2:
  - byte at 0x13, signed → 0xFFFFFFDE
  - byte at 0x13, unsigned → 0x000000DE
  - half at 0x12, signed → 0xFFFFDEA5
  - half at 0x10, unsigned → 0x0000BEEF
- **Misaligned word load at 0x11:**
  - With the macro: `fault`=1 in T+1, `mem_we` never 1, `rvalid` stays 0.
  - Without the macro: `mem_addr`=0x10 and `rdata`=0xDEA5BEEF in T+2.
- **Reset during RD** of a half store → `mem_we` never asserts, the memory word is unchanged, and `ready`=1 immediately.

Source files
------------

// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store front-end for a word-wide, byte-addressed
// little-endian data memory. Sub-word stores become read-modify-write pairs;
// loads are lane-extracted and zero/sign-extended into a registered result.
// Optional feature: define MEM_ACCESS_ALIGN_CHECK_EN to reject misaligned
// half/word accesses and size=11 through a FAULT state.
module mem_access_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_req,
    input  logic        i_we,
    input  logic [1:0]  i_size,
    input  logic        i_sign_ext,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    output logic        o_ready,
    output logic        o_rvalid,
    output logic [31:0] o_rdata,
    output logic        o_fault,
    output logic        o_mem_we,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    input  logic [31:0] i_mem_rdata
);

    localparam int unsigned DW = 32;
    localparam int unsigned HW = 16;
    localparam int unsigned BW = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RD,
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
        S_FAULT,
`endif
        S_WR
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;

    logic [1:0]      r_lane;
    logic [1:0]      r_size;
    logic            r_sign;
    logic [HW-1:0]   r_wdata;

    logic            r_rvalid;
    logic [DW-1:0]   r_rdata;
    logic            r_mem_we;
    logic [DW-1:0]   r_mem_addr;
    logic [DW-1:0]   r_mem_wdata;

    logic [BW-1:0]   w_byte;
    logic [HW-1:0]   w_half;
    logic [DW-1:0]   w_ld_val;
    logic [DW-1:0]   w_merge_val;

`ifdef MEM_ACCESS_ALIGN_CHECK_EN
    logic            r_fault;
    logic            w_misalign;

    // Rejected accesses: misaligned half/word or the reserved size
    always_comb begin
        w_misalign = (i_size == 2'b11)
                   || ((i_size == 2'b10) && (i_addr[1:0] != 2'b00))
                   || ((i_size == 2'b01) && i_addr[0]);
    end

    assign o_fault = r_fault;
`else
    assign o_fault = 1'b0;
`endif

    assign o_ready     = (r_state == S_IDLE);
    assign o_rvalid    = r_rvalid;
    assign o_rdata     = r_rdata;
    assign o_mem_we    = r_mem_we;
    assign o_mem_addr  = r_mem_addr;
    assign o_mem_wdata = r_mem_wdata;

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state; size[1] set means a whole-word access
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_req) begin
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
                    if (w_misalign)
                        w_state_nxt = S_FAULT;
                    else
`endif
                    if (!i_we)
                        w_state_nxt = S_LOAD;
                    else if (i_size[1])
                        w_state_nxt = S_WR;
                    else
                        w_state_nxt = S_RD;
                end
            end
            S_LOAD:  w_state_nxt = S_IDLE;
            S_RD:    w_state_nxt = S_WR;
            S_WR:    w_state_nxt = S_IDLE;
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
            S_FAULT: w_state_nxt = S_IDLE;
`endif
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Lane extraction for loads and lane merge for sub-word stores
    always_comb begin
        case (r_lane)
            2'd0:    w_byte = i_mem_rdata[7:0];
            2'd1:    w_byte = i_mem_rdata[15:8];
            2'd2:    w_byte = i_mem_rdata[23:16];
            default: w_byte = i_mem_rdata[31:24];
        endcase
        w_half = r_lane[1] ? i_mem_rdata[31:16] : i_mem_rdata[15:0];

        case (r_size)
            2'b00:   w_ld_val = {{(DW-BW){r_sign & w_byte[BW-1]}}, w_byte};
            2'b01:   w_ld_val = {{(DW-HW){r_sign & w_half[HW-1]}}, w_half};
            default: w_ld_val = i_mem_rdata;
        endcase

        w_merge_val = i_mem_rdata;
        if (r_size == 2'b00) begin
            case (r_lane)
                2'd0:    w_merge_val[7:0]   = r_wdata[7:0];
                2'd1:    w_merge_val[15:8]  = r_wdata[7:0];
                2'd2:    w_merge_val[23:16] = r_wdata[7:0];
                default: w_merge_val[31:24] = r_wdata[7:0];
            endcase
        end else if (r_lane[1]) begin
            w_merge_val[31:16] = r_wdata;
        end else begin
            w_merge_val[15:0] = r_wdata;
        end
    end

    // Request capture, memory-side outputs and load result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lane      <= 2'b00;
            r_size      <= 2'b00;
            r_sign      <= 1'b0;
            r_wdata     <= '0;
            r_rvalid    <= 1'b0;
            r_rdata     <= '0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
            r_fault     <= 1'b0;
`endif
        end else begin
            r_rvalid <= 1'b0;
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
            r_fault  <= 1'b0;
`endif
            case (r_state)
                S_IDLE: begin
                    if (i_req) begin
                        r_lane  <= i_addr[1:0];
                        r_size  <= i_size;
                        r_sign  <= i_sign_ext;
                        r_wdata <= i_wdata[HW-1:0];
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
                        if (w_misalign)
                            r_fault <= 1'b1;
                        else
`endif
                        begin
                            r_mem_addr <= {i_addr[31:2], 2'b00};
                            if (i_we && i_size[1]) begin
                                r_mem_we    <= 1'b1;
                                r_mem_wdata <= i_wdata;
                            end
                        end
                    end
                end
                S_LOAD: begin
                    r_rdata  <= w_ld_val;
                    r_rvalid <= 1'b1;
                end
                S_RD: begin
                    r_mem_wdata <= w_merge_val;
                    r_mem_we    <= 1'b1;
                end
                S_WR: begin
                    r_mem_we <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit with a small word memory model.
// Load results are scoreboarded; control/memory-side timing is checked inline.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req;
    logic        we;
    logic [1:0]  size;
    logic        sign_ext;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        ready;
    logic        rvalid;
    logic [31:0] rdata;
    logic        fault;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic [31:0] mem [0:63];
    logic [31:0] sb_q [$];
    int          n_checks = 0;
    int          n_fail   = 0;

    mem_access_unit dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_req       (req),
        .i_we        (we),
        .i_size      (size),
        .i_sign_ext  (sign_ext),
        .i_addr      (addr),
        .i_wdata     (wdata),
        .o_ready     (ready),
        .o_rvalid    (rvalid),
        .o_rdata     (rdata),
        .o_fault     (fault),
        .o_mem_we    (mem_we),
        .o_mem_addr  (mem_addr),
        .o_mem_wdata (mem_wdata),
        .i_mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    // Word memory: combinational read, write on the rising edge
    assign mem_rdata = mem[mem_addr[7:2]];
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr[7:2]] <= mem_wdata;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every rvalid pulse consumes one expected load result
    always @(negedge clk) begin
        if (rst_n && rvalid) begin
            if (sb_q.size() == 0)
                check_eq("unexpected_rvalid", 32'(rvalid), 32'd0);
            else
                check_eq("rdata", rdata, sb_q.pop_front());
        end
    end

    // Called at a negedge; drives one request, returns at the negedge of T+1
    task automatic issue(input logic w, input logic [1:0] sz, input logic sx,
                         input logic [31:0] a, input logic [31:0] wd);
        check_eq("ready_before_accept", 32'(ready), 32'd1);
        req = 1'b1; we = w; size = sz; sign_ext = sx; addr = a; wdata = wd;
        @(negedge clk);
        req = 1'b0;
        we = 1'($urandom); size = 2'($urandom); sign_ext = 1'($urandom);
        addr = $urandom; wdata = $urandom;
        check_eq("ready_t1", 32'(ready), 32'd0);
        check_eq("rvalid_t1", 32'(rvalid), 32'd0);
    endtask

    task automatic do_load(input logic [1:0] sz, input logic sx, input logic [31:0] a,
                           input logic [31:0] exp);
        sb_q.push_back(exp);
        issue(1'b0, sz, sx, a, 32'h0);
        check_eq("ld_mem_addr", mem_addr, {a[31:2], 2'b00});
        check_eq("ld_mem_we_t1", 32'(mem_we), 32'd0);
        check_eq("ld_fault_t1", 32'(fault), 32'd0);
        @(negedge clk);
        check_eq("ld_rvalid_t2", 32'(rvalid), 32'd1);
        check_eq("ld_ready_t2", 32'(ready), 32'd1);
    endtask

    task automatic do_store_word(input logic [31:0] a, input logic [31:0] wd);
        issue(1'b1, 2'b10, 1'b0, a, wd);
        check_eq("sw_mem_we_t1", 32'(mem_we), 32'd1);
        check_eq("sw_mem_addr", mem_addr, {a[31:2], 2'b00});
        check_eq("sw_mem_wdata", mem_wdata, wd);
        @(negedge clk);
        check_eq("sw_ready_t2", 32'(ready), 32'd1);
        check_eq("sw_mem_we_t2", 32'(mem_we), 32'd0);
        check_eq("sw_mem_word", mem[a[7:2]], wd);
    endtask

    task automatic do_store_part(input logic [1:0] sz, input logic [31:0] a,
                                 input logic [31:0] wd, input logic [31:0] exp_word);
        issue(1'b1, sz, 1'b0, a, wd);
        check_eq("sp_mem_we_t1", 32'(mem_we), 32'd0);
        check_eq("sp_mem_addr", mem_addr, {a[31:2], 2'b00});
        @(negedge clk);
        check_eq("sp_mem_we_t2", 32'(mem_we), 32'd1);
        check_eq("sp_mem_wdata", mem_wdata, exp_word);
        check_eq("sp_ready_t2", 32'(ready), 32'd0);
        @(negedge clk);
        check_eq("sp_ready_t3", 32'(ready), 32'd1);
        check_eq("sp_mem_we_t3", 32'(mem_we), 32'd0);
        check_eq("sp_mem_word", mem[a[7:2]], exp_word);
    endtask

`ifdef MEM_ACCESS_ALIGN_CHECK_EN
    task automatic do_fault(input logic w, input logic [1:0] sz, input logic [31:0] a);
        logic [31:0] before;
        before = mem[a[7:2]];
        issue(w, sz, 1'b0, a, 32'h0BAD_F00D);
        check_eq("flt_fault_t1", 32'(fault), 32'd1);
        check_eq("flt_mem_we_t1", 32'(mem_we), 32'd0);
        @(negedge clk);
        check_eq("flt_fault_t2", 32'(fault), 32'd0);
        check_eq("flt_rvalid_t2", 32'(rvalid), 32'd0);
        check_eq("flt_mem_we_t2", 32'(mem_we), 32'd0);
        check_eq("flt_ready_t2", 32'(ready), 32'd1);
        check_eq("flt_mem_word", mem[a[7:2]], before);
    endtask
`endif

    // Bound the run in case the DUT stalls
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; req = 1'b0; we = 1'b0; size = 2'b00; sign_ext = 1'b0;
        addr = 32'h0; wdata = 32'h0;
        repeat (2) @(negedge clk);
        check_eq("rst_ready", 32'(ready), 32'd1);
        check_eq("rst_mem_we", 32'(mem_we), 32'd0);
        check_eq("rst_rvalid", 32'(rvalid), 32'd0);
        check_eq("rst_rdata", rdata, 32'h0);
        check_eq("rst_fault", 32'(fault), 32'd0);
        check_eq("rst_mem_addr", mem_addr, 32'h0);
        check_eq("rst_mem_wdata", mem_wdata, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        do_store_word(32'h10, 32'hDEAD_BEEF);
        do_store_part(2'b00, 32'h12, 32'h0000_00A5, 32'hDEA5_BEEF);

        // Loads issued back-to-back on the rvalid cycle of the previous one
        do_load(2'b00, 1'b1, 32'h13, 32'hFFFF_FFDE);
        do_load(2'b00, 1'b0, 32'h13, 32'h0000_00DE);
        do_load(2'b01, 1'b1, 32'h12, 32'hFFFF_DEA5);
        do_load(2'b01, 1'b0, 32'h10, 32'h0000_BEEF);
        do_load(2'b10, 1'b1, 32'h10, 32'hDEA5_BEEF);
        do_load(2'b00, 1'b1, 32'h10, 32'hFFFF_FFEF);
        do_load(2'b00, 1'b0, 32'h11, 32'h0000_00BE);
        do_load(2'b01, 1'b1, 32'h10, 32'hFFFF_BEEF);

`ifdef MEM_ACCESS_ALIGN_CHECK_EN
        do_fault(1'b0, 2'b10, 32'h11);
        do_fault(1'b1, 2'b10, 32'h13);
        do_fault(1'b0, 2'b01, 32'h11);
        do_fault(1'b1, 2'b11, 32'h10);
`else
        do_load(2'b10, 1'b0, 32'h11, 32'hDEA5_BEEF);
        do_load(2'b11, 1'b0, 32'h10, 32'hDEA5_BEEF);
        do_load(2'b01, 1'b0, 32'h13, 32'h0000_DEA5);
`endif

        // Reset while the half store sits in RD: no write may reach memory
        issue(1'b1, 2'b01, 1'b0, 32'h12, 32'h0000_1234);
        check_eq("rrd_mem_we_t1", 32'(mem_we), 32'd0);
        rst_n = 1'b0;
        #1;
        check_eq("rrd_ready", 32'(ready), 32'd1);
        check_eq("rrd_mem_we", 32'(mem_we), 32'd0);
        check_eq("rrd_rvalid", 32'(rvalid), 32'd0);
        check_eq("rrd_rdata", rdata, 32'h0);
        check_eq("rrd_mem_addr", mem_addr, 32'h0);
        @(negedge clk);
        check_eq("rrd_mem_we_hold", 32'(mem_we), 32'd0);
        @(negedge clk);
        check_eq("rrd_mem_word", mem[4], 32'hDEA5_BEEF);
        rst_n = 1'b1;
        @(negedge clk);

        do_store_part(2'b01, 32'h12, 32'hABCD_1234, 32'h1234_BEEF);
        do_store_part(2'b00, 32'h10, 32'h0000_0077, 32'h1234_BE77);
        do_store_part(2'b00, 32'h11, 32'hFFFF_FF5A, 32'h1234_5A77);
        do_store_part(2'b01, 32'h10, 32'h0000_8001, 32'h1234_8001);
        do_load(2'b10, 1'b0, 32'h10, 32'h1234_8001);
        do_load(2'b01, 1'b1, 32'h10, 32'hFFFF_8001);
        do_store_word(32'h20, 32'h0102_0304);
        do_load(2'b00, 1'b0, 32'h22, 32'h0000_0002);

        repeat (3) @(negedge clk);
        check_eq("sb_leftover", 32'(sb_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
